// File: rtl/cache_sa.sv
// Set-associative (1 or 2 way) write-back, write-allocate data cache sitting between
// the CPU load/store port and a line-granular valid/ready memory port.
module cache_sa #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 256,
  parameter int WAYS       = 2
) (
  input  logic                         cpu_clk_i,
  input  logic                         reset_i,
  input  logic                         req_valid_i,
  input  logic                         req_is_write_i,
  input  logic [ADDR_W-1:0]            req_addr_i,
  input  logic [DATA_W-1:0]            req_data_i,
  input  logic [DATA_W/8-1:0]          req_be_i,
  output logic [DATA_W-1:0]            res_data_o,
  output logic                         res_ready_o,
  output logic                         mem_req_valid_o,
  output logic                         mem_req_is_write_o,
  output logic [ADDR_W-1:0]            mem_req_addr_o,
  output logic [LINE_WORDS*DATA_W-1:0] mem_req_data_o,
  input  logic                         mem_req_ready_i,
  input  logic                         mem_res_valid_i,
  input  logic [LINE_WORDS*DATA_W-1:0] mem_res_data_i
);
  localparam int BE_W   = DATA_W / 8;
  localparam int LINE_W = LINE_WORDS * DATA_W;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int LOW_W  = WORD_W + OFF_W;
  localparam int TAG_W  = ADDR_W - IDX_W - LOW_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} state_t;
  state_t state_q, state_d;

  logic [LINE_W-1:0] data_q  [WAYS][SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   dirty_q [WAYS];
  logic [SETS-1:0]   lru_q;

  logic              req_write_q, req_write_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;
  logic [IDX_W-1:0]  req_idx_q, req_idx_d;
  logic [WORD_W-1:0] req_word_q, req_word_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic [BE_W-1:0]   req_be_q, req_be_d;

  logic              victim_q, victim_d;
  logic              fill_sent_q, fill_sent_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;

  logic              line_we, line_way, line_dirty, lru_we;
  logic [WAYS-1:0]   hit_vec;
  logic              hit, hit_way, victim_sel, any_invalid, victim_dirty;
  logic [LINE_W-1:0] hit_line, victim_line, merge_base, merged_line;
  logic [DATA_W-1:0] load_word;
  logic [ADDR_W-1:0] fill_addr, victim_addr;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr_i[OFF_W-1:0];

  // Tag compare plus victim choice: lowest invalid way first, otherwise the LRU way.
  always_comb begin
    hit_vec     = '0;
    hit_way     = 1'b0;
    victim_sel  = 1'b0;
    any_invalid = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = valid_q[w][req_idx_q] && (tag_q[w][req_idx_q] == req_tag_q);
      if (hit_vec[w]) hit_way = 1'(w);
      if (!valid_q[w][req_idx_q]) begin
        victim_sel  = 1'(w);
        any_invalid = 1'b1;
      end
    end
    if (!any_invalid && WAYS > 1) victim_sel = lru_q[req_idx_q];
    hit = |hit_vec;
  end

  assign hit_line     = data_q[hit_way][req_idx_q];
  assign victim_line  = data_q[victim_sel][req_idx_q];
  assign victim_dirty = valid_q[victim_sel][req_idx_q] && dirty_q[victim_sel][req_idx_q];
  assign victim_addr  = {tag_q[victim_sel][req_idx_q], req_idx_q, {LOW_W{1'b0}}};
  assign fill_addr    = {req_tag_q, req_idx_q, {LOW_W{1'b0}}};

  // The same byte-merge serves store hits (old line) and store fills (incoming line).
  always_comb begin
    merge_base  = (state_q == FILL) ? mem_res_data_i : hit_line;
    merged_line = merge_base;
    if (req_write_q) begin
      for (int b = 0; b < BE_W; b++) begin
        if (req_be_q[b])
          merged_line[int'(req_word_q)*DATA_W + b*8 +: 8] = req_data_q[b*8 +: 8];
      end
    end
    load_word = merge_base[int'(req_word_q)*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d     = state_q;
    req_write_d = req_write_q;
    req_tag_d   = req_tag_q;
    req_idx_d   = req_idx_q;
    req_word_d  = req_word_q;
    req_data_d  = req_data_q;
    req_be_d    = req_be_q;
    victim_d    = victim_q;
    fill_sent_d = fill_sent_q;
    res_data_d  = res_data_q;
    mem_valid_d = mem_valid_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    line_we     = 1'b0;
    line_way    = victim_q;
    line_dirty  = 1'b0;
    lru_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          req_write_d = req_is_write_i;
          req_tag_d   = req_addr_i[ADDR_W-1 -: TAG_W];
          req_idx_d   = req_addr_i[LOW_W +: IDX_W];
          req_word_d  = req_addr_i[OFF_W +: WORD_W];
          req_data_d  = req_data_i;
          req_be_d    = req_be_i;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          line_we    = req_write_q;
          line_way   = hit_way;
          line_dirty = 1'b1;
          lru_we     = 1'b1;
          if (!req_write_q) res_data_d = load_word;
          state_d = RESPOND;
        end else begin
          victim_d    = victim_sel;
          fill_sent_d = 1'b0;
          mem_valid_d = 1'b1;
          if (victim_dirty) begin
            mem_write_d = 1'b1;
            mem_addr_d  = victim_addr;
            mem_data_d  = victim_line;
            state_d     = WRITEBACK;
          end else begin
            mem_write_d = 1'b0;
            mem_addr_d  = fill_addr;
            state_d     = FILL;
          end
        end
      end
      WRITEBACK: begin
        if (mem_req_ready_i) begin
          mem_valid_d = 1'b0;
          state_d     = FILL;
        end
      end
      // After a writeback the fill request is raised one cycle after valid dropped.
      FILL: begin
        if (!fill_sent_q) begin
          if (!mem_valid_q) begin
            mem_valid_d = 1'b1;
            mem_write_d = 1'b0;
            mem_addr_d  = fill_addr;
          end else if (mem_req_ready_i) begin
            mem_valid_d = 1'b0;
            fill_sent_d = 1'b1;
          end
        end else if (mem_res_valid_i) begin
          line_we    = 1'b1;
          line_way   = victim_q;
          line_dirty = req_write_q;
          lru_we     = 1'b1;
          if (!req_write_q) res_data_d = load_word;
          state_d = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      req_write_q <= 1'b0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_word_q  <= '0;
      req_data_q  <= '0;
      req_be_q    <= '0;
      victim_q    <= 1'b0;
      fill_sent_q <= 1'b0;
      res_data_q  <= '0;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_write_q <= req_write_d;
      req_tag_q   <= req_tag_d;
      req_idx_q   <= req_idx_d;
      req_word_q  <= req_word_d;
      req_data_q  <= req_data_d;
      req_be_q    <= req_be_d;
      victim_q    <= victim_d;
      fill_sent_q <= fill_sent_d;
      res_data_q  <= res_data_d;
      mem_valid_q <= mem_valid_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  // Line payload and tags need no reset; valid bits alone decide whether they count.
  always_ff @(posedge cpu_clk_i) begin
    if (line_we) begin
      data_q[line_way][req_idx_q] <= merged_line;
      tag_q[line_way][req_idx_q]  <= req_tag_q;
    end
  end

  always_ff @(posedge cpu_clk_i) begin
    if (reset_i) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      lru_q <= '0;
    end else begin
      if (line_we) begin
        valid_q[line_way][req_idx_q] <= 1'b1;
        dirty_q[line_way][req_idx_q] <= line_dirty;
      end
      if (lru_we && WAYS > 1) lru_q[req_idx_q] <= ~line_way;
    end
  end

  assign res_ready_o        = (state_q == RESPOND);
  assign res_data_o         = res_data_q;
  assign mem_req_valid_o    = mem_valid_q;
  assign mem_req_is_write_o = mem_write_q;
  assign mem_req_addr_o     = mem_addr_q;
  assign mem_req_data_o     = mem_data_q;
endmodule

// File: doc/cache_sa.md
# cache_sa

Parametrised set-associative, write-back, write-allocate data cache between the CPU load/store port and a generic line-granular memory port. It is the successor to the direct-mapped `cache` and keeps the same CPU-side request/response handshake. It adds configurable ways, line size and set count, per-byte write enables, and a plain valid/ready memory interface that a MIG bridge sits behind. It runs entirely in the CPU clock domain.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, CPU word width (multiple of 8)
- LINE_WORDS, 4, words per line (power of 2; 4 gives a 16-byte line)
- SETS, 256, number of sets (power of 2)
- WAYS, 2, associativity; legal values 1 or 2
- cpu_clk  in  1  clock; one clock; reset is synchronous and active-high
- reset  in  1  synchronous active-high reset, sampled on the cpu_clk rising edge
- req_valid  in  1  CPU request present; held with all req_* stable until res_ready
- req_is_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address; low log2(DATA_W/8) bits ignored
- req_data  in  DATA_W  store data
- req_be  in  DATA_W/8  store byte enables; ignored on loads
- res_data  out  DATA_W  load data, valid while res_ready=1
- res_ready  out  1  one-cycle completion pulse
- mem_req_valid  out  1  memory request present
- mem_req_is_write  out  1  1 = line writeback, 0 = line fill
- mem_req_addr  out  ADDR_W  line-aligned byte address
- mem_req_data  out  LINE_WORDS*DATA_W  writeback line; word 0 in the LSBs
- mem_req_ready  in  1  memory accepts the request on an edge where valid and ready are both 1
- mem_res_valid  in  1  fill data present (one cycle)
- mem_res_data  in  LINE_WORDS*DATA_W  fill line

## Operation
- Address split, LSB first:
  - byte offset: log2(DATA_W/8) bits
  - word: log2(LINE_WORDS) bits
  - index: log2(SETS) bits
  - tag: remaining bits
- Per line: valid bit, dirty bit, tag, data. Per set: one LRU bit (WAYS=2), which names the next victim way.
- States are IDLE, LOOKUP, WRITEBACK, FILL, RESPOND.
- IDLE
  - req_valid=1 latches the request into internal registers and moves to LOOKUP.
  - req_* are not re-sampled until the state returns to IDLE.
- LOOKUP, hit (valid and tag match)
  - A load captures the word into res_data.
  - A store merges req_data into the line under req_be and sets dirty.
  - Sets LRU to the other way, then moves to RESPOND.
- LOOKUP, miss, victim selection
  - The first invalid way is chosen, way 0 before way 1.
  - If no way is invalid, the LRU way is chosen.
  - A dirty victim goes to WRITEBACK; otherwise to FILL.
- WRITEBACK
  - Drives mem_req_valid=1, is_write=1, the victim's address {victim tag, index, 0} and the victim's data.
  - On the handshake edge, moves to FILL.
- FILL
  - Drives mem_req_valid=1, is_write=0, the request's line address until the handshake.
  - Then waits for mem_res_valid and writes the fill line, tag and valid=1 into the victim way.
  - A store merges under req_be in the same write and sets dirty=1. A load leaves dirty=0.
  - Sets LRU to the other way; the load word is taken from the fill line. Moves to RESPOND.
- RESPOND: res_ready=1 for exactly this cycle, then back to IDLE.
- mem_res_valid outside the wait-for-fill phase is ignored.
- WAYS=1: the LRU bit is absent and the single way is always the victim.

## Timing
- Reset values:
  - res_ready=0, res_data=0, mem_req_valid=0, mem_req_is_write=0, mem_req_addr=0, mem_req_data=0.
  - All valid, dirty and LRU bits = 0; state = IDLE.
- Hit latency: accept edge E; LOOKUP during E+1; res_ready high during cycle E+2.
  - With req_valid held continuously, back-to-back hits complete every 3 cycles.
- Clean-miss latency is 3 cycles plus memory latency, measured from the mem_req handshake to mem_res_valid. A dirty miss adds the writeback handshake time.
- mem_req_* are registered and stay stable while mem_req_valid=1 and mem_req_ready=0.
- mem_req_valid is deasserted in the cycle after the handshake edge.
- Reset in any state takes effect on the next edge:
  - The request is abandoned, mem_req_valid drops and everything is invalidated.
  - Dirty data is lost.
  - A mem_res_valid arriving after reset is ignored.
- Simultaneous reset and req_valid: reset wins and the request is not accepted.

## Test plan
- Defaults (16-byte lines, 256 sets, 2 ways). After reset: store 1 to addr 0, store 7 to addr 16, load 0, load 16.
  - Required: two fills at line addresses 0x0 and 0x10; loads return 1 and 7 with no further memory traffic; no writebacks.
- Hit timing: repeat load 0 with req_valid held.
  - Required: res_ready pulses exactly every 3 cycles; mem_req_valid stays 0.
- Conflict eviction: store 0xA to addr 0x0, then 0xB to 0x1000, 0xC to 0x2000 (same set), then load 0x0.
  - Required: the third store writes back line 0x0 with word0=0xA.
  - The final load refills 0x0, evicting dirty 0x1000 with a writeback, and returns 0xA.
- Byte enables: store 0xFFFFFFFF be=0xF, then store 0x00000012 be=0x1 to the same address, then load.
  - Required: the load returns 0xFFFFFF12.
- Backpressure: hold mem_req_ready=0 for 20 cycles during a fill.
  - Required: mem_req_* are stable throughout; the fill completes normally afterwards.
- Reset mid-fill: assert reset while waiting for mem_res_valid, then pulse mem_res_valid.
  - Required: IDLE; no res_ready; a following load of the same address misses and issues a new fill.
